// File: rtl/ori_hist_acc.sv
// rtl/ori_hist_acc.sv - 32-bin orientation histogram accumulator with dominant-bin scan
module ori_hist_acc #(
  parameter int MAG_W = 8,
  parameter int ACC_W = 16,
  parameter int NSAMP = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [4:0]       s_dir,
  input  logic [MAG_W-1:0] s_mag,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [4:0]       m_bin,
  output logic [ACC_W-1:0] m_peak,
  output logic             busy
);

  localparam int CW = (NSAMP > 1) ? $clog2(NSAMP) : 1;
  localparam int SW = ((ACC_W > MAG_W) ? ACC_W : MAG_W) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  typedef enum logic [1:0] {ST_ACC, ST_SCAN, ST_OUT, ST_CLEAR} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [4:0]       idx_q, idx_d;
  logic [ACC_W-1:0] run_max_q, run_max_d;
  logic [4:0]       run_bin_q, run_bin_d;
  logic [ACC_W-1:0] m_peak_q, m_peak_d;
  logic [4:0]       m_bin_q, m_bin_d;
  logic [ACC_W-1:0] bin_q [32];

  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [ACC_W-1:0] wr_data;
  logic [ACC_W-1:0] cand_max;
  logic [4:0]       cand_bin;

  // Saturating add of the incoming magnitude onto the addressed bin; the sum is
  // one bit wider than either operand so an overflow is visible before clamping.
  logic [SW-1:0]    sum_w;
  logic [ACC_W-1:0] sat_sum;
  assign sum_w   = SW'(bin_q[s_dir]) + SW'(s_mag);
  assign sat_sum = (sum_w > SW'(ACC_MAX)) ? ACC_MAX : sum_w[ACC_W-1:0];

  assign m_bin  = m_bin_q;
  assign m_peak = m_peak_q;
  assign busy   = !((state_q == ST_ACC) && (cnt_q == '0));

  // Next-state, datapath control and handshake outputs for the four phases.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    run_max_d = run_max_q;
    run_bin_d = run_bin_q;
    m_peak_d  = m_peak_q;
    m_bin_d   = m_bin_q;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = s_dir;
    wr_data   = sat_sum;
    cand_max  = run_max_q;
    cand_bin  = run_bin_q;
    case (state_q)
      ST_ACC: begin
        s_ready = 1'b1;
        if (s_valid) begin
          wr_en = 1'b1;
          if (cnt_q == CW'(NSAMP - 1)) begin
            cnt_d     = '0;
            idx_d     = '0;
            run_max_d = '0;
            run_bin_d = '0;
            state_d   = ST_SCAN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_SCAN: begin
        // Strictly-greater keeps the earliest (lowest) index on ties.
        if (bin_q[idx_q] > run_max_q) begin
          cand_max = bin_q[idx_q];
          cand_bin = idx_q;
        end
        run_max_d = cand_max;
        run_bin_d = cand_bin;
        if (idx_q == 5'd31) begin
          m_peak_d = cand_max;
          m_bin_d  = cand_bin;
          idx_d    = '0;
          state_d  = ST_OUT;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      ST_OUT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          idx_d   = '0;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = idx_q;
        wr_data = '0;
        if (idx_q == 5'd31) begin
          idx_d   = '0;
          state_d = ST_ACC;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  // Control and result registers; reset abandons any window in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ACC;
      cnt_q     <= '0;
      idx_q     <= '0;
      run_max_q <= '0;
      run_bin_q <= '0;
      m_peak_q  <= '0;
      m_bin_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      run_max_q <= run_max_d;
      run_bin_q <= run_bin_d;
      m_peak_q  <= m_peak_d;
      m_bin_q   <= m_bin_d;
    end
  end

  // Histogram bins: one write port shared by accumulation and clearing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) bin_q[i] <= '0;
    end else if (wr_en) begin
      bin_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_ori_hist_acc.sv
// tb/tb_ori_hist_acc.sv - directed self-checking bench for ori_hist_acc
module tb_ori_hist_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [4:0]  s_dir;
  logic [7:0]  s_mag;
  logic        m_ready;

  logic        s_ready, m_valid, busy;
  logic [4:0]  m_bin;
  logic [15:0] m_peak;

  logic        s_ready12, m_valid12, busy12;
  logic [4:0]  m_bin12;
  logic [11:0] m_peak12;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_last = 0;

  logic [4:0] dir_a [256];
  logic [7:0] mag_a [256];

  ori_hist_acc #(.MAG_W(8), .ACC_W(16), .NSAMP(256)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_dir(s_dir), .s_mag(s_mag), .m_valid(m_valid), .m_ready(m_ready),
    .m_bin(m_bin), .m_peak(m_peak), .busy(busy)
  );

  ori_hist_acc #(.MAG_W(8), .ACC_W(12), .NSAMP(256)) dut12 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready12),
    .s_dir(s_dir), .s_mag(s_mag), .m_valid(m_valid12), .m_ready(m_ready),
    .m_bin(m_bin12), .m_peak(m_peak12), .busy(busy12)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [4:0] d, input logic [7:0] m);
    for (int i = 0; i < 256; i++) begin
      dir_a[i] = d;
      mag_a[i] = m;
    end
  endtask

  task automatic send_window(input string tag, input int n);
    int nr;
    nr = 0;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_dir   = dir_a[i];
      s_mag   = mag_a[i];
      if (!s_ready) nr++;
      t_last = cyc;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    check($sformatf("%s_rdy", tag), nr, 0);
  endtask

  task automatic wait_result(input string tag, input int eb, input int ep);
    int n;
    n = 0;
    while (!m_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("%s_valid", tag), m_valid, 1);
    check($sformatf("%s_lat", tag), cyc - t_last, 33);
    check($sformatf("%s_bin", tag), m_bin, eb);
    check($sformatf("%s_peak", tag), m_peak, ep);
  endtask

  task automatic handshake(input string tag);
    int n;
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    check($sformatf("%s_vdrop", tag), m_valid, 0);
    n = 0;
    while (!s_ready && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check($sformatf("%s_clrlen", tag), n, 32);
    check($sformatf("%s_idle", tag), busy, 0);
  endtask

  initial begin
    int k, nv;
    rst = 1'b1; s_valid = 1'b0; s_dir = '0; s_mag = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_sready", s_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_mvalid", m_valid, 0);
    check("rst_mbin", m_bin, 0);
    check("rst_mpeak", m_peak, 0);

    // Uniform bin 7, then hold result with m_ready low.
    fill(5'd7, 8'd10);
    send_window("w7", 256);
    wait_result("w7", 7, 2560);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_valid", m_valid, 1);
      check("hold_bin", m_bin, 7);
      check("hold_peak", m_peak, 2560);
      check("hold_sready", s_ready, 0);
    end
    handshake("w7");
    check("keep_bin", m_bin, 7);
    check("keep_peak", m_peak, 2560);

    // Saturation: 65280 fits 16 bits, clamps to 4095 in 12 bits.
    fill(5'd3, 8'd255);
    send_window("sat", 256);
    wait_result("sat", 3, 65280);
    check("sat12_valid", m_valid12, 1);
    check("sat12_bin", m_bin12, 3);
    check("sat12_peak", m_peak12, 4095);
    handshake("sat");

    // Tie between bins 5 and 20 at 500 each; others get small counts.
    dir_a[0] = 5'd20; mag_a[0] = 8'd250;
    dir_a[1] = 5'd5;  mag_a[1] = 8'd250;
    dir_a[2] = 5'd20; mag_a[2] = 8'd250;
    dir_a[3] = 5'd5;  mag_a[3] = 8'd200;
    dir_a[4] = 5'd5;  mag_a[4] = 8'd50;
    for (int i = 5; i < 256; i++) begin
      k = i % 30;
      dir_a[i] = (k < 5) ? 5'(k) : (k < 19) ? 5'(k + 1) : 5'(k + 2);
      mag_a[i] = 8'd1;
    end
    send_window("tie", 256);
    wait_result("tie", 5, 500);
    handshake("tie");

    // Next window after CLEAR must see empty bins.
    fill(5'd31, 8'd1);
    send_window("w31", 256);
    wait_result("w31", 31, 256);
    handshake("w31");

    // Abort a partial window with reset.
    fill(5'd9, 8'd200);
    send_window("part", 100);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_sready", s_ready, 1);
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_valid || m_valid12) nv++;
      @(posedge clk); #1;
    end
    check("abort_novalid", nv, 0);
    fill(5'd12, 8'd2);
    send_window("fresh", 256);
    wait_result("fresh", 12, 512);
    check("fresh12_bin", m_bin12, 12);
    check("fresh12_peak", m_peak12, 512);
    handshake("fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ori_hist_acc.md
ORI_HIST_ACC -- requirements
Module: ori_hist_acc

Interface
REQ-001 SHALL have parameter MAG_W, default 8, gradient-magnitude width.
REQ-002 SHALL have parameter ACC_W, default 16, histogram-bin accumulator width.
REQ-003 SHALL have parameter NSAMP, default 256, samples per keypoint window (16x16 patch).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 s_valid  input  1  input sample valid.
REQ-007 s_ready  output  1  block can accept a sample.
REQ-008 s_dir  input  5  orientation bin 0..31 from the upstream 8-bit-address direction ROM.
REQ-009 s_mag  input  MAG_W  gradient magnitude, unsigned.
REQ-010 m_valid  output  1  dominant-orientation result valid.
REQ-011 m_ready  input  1  downstream accepts result.
REQ-012 m_bin  output  5  index of the peak histogram bin.
REQ-013 m_peak  output  ACC_W  accumulated value of the peak bin.
REQ-014 busy  output  1  high in any state other than ACC with zero samples accepted.

Function
REQ-015 SHALL hold 32 bins of ACC_W bits, one per orientation bin.
REQ-016 SHALL implement states ACC, SCAN, OUT, CLEAR.
REQ-017 ACC: s_ready=1; a sample transfers when s_valid&&s_ready; bin[s_dir] += s_mag, zero-extended.
REQ-018 Bin addition SHALL saturate at 2^ACC_W-1, never wrap.
REQ-019 Back-to-back samples to the same bin SHALL all accumulate, with no lost updates and no stall.
REQ-020 ACC SHALL count accepted samples; the NSAMP-th transfer moves to SCAN next cycle, with the count reset to 0.
REQ-021 SCAN: s_ready=0; 32 cycles, one bin per cycle, index 0..31 ascending.
REQ-022 SCAN: a bin replaces the running max only if strictly greater, so ties resolve to the lowest index.
REQ-023 SCAN: if all bins are 0, result SHALL be m_bin=0, m_peak=0.
REQ-024 SCAN: after index 31 is compared, the block moves to OUT.
REQ-025 Latency: last sample accepted in cycle t gives m_valid=1 in cycle t+33.
REQ-026 OUT: m_valid=1, m_bin/m_peak stable, s_ready=0; hold until m_ready=1.
REQ-027 OUT with m_ready high SHALL complete the handshake and move to CLEAR; m_valid drops the next cycle.
REQ-028 CLEAR: s_ready=0; 32 cycles, zeroing bin i in cycle i, then move to ACC.
REQ-029 m_bin/m_peak SHALL retain their last result outside OUT; only m_valid qualifies them.
REQ-030 s_dir is 5 bits, so every value is legal; no out-of-range handling.
REQ-031 s_valid while s_ready=0 SHALL have no effect; upstream holds the sample.

Reset
REQ-032 rst high SHALL asynchronously force all of the following:
- state=ACC, sample count=0, all 32 bins=0;
- m_valid=0, m_bin=0, m_peak=0;
- s_ready=1 and busy=0 after release.
REQ-033 rst asserted mid-ACC, mid-SCAN, mid-OUT or mid-CLEAR SHALL abort the window; no partial result is emitted.

Verification
REQ-034 Bench SHALL cover: 256 samples all s_dir=7, s_mag=10 -> m_bin=7, m_peak=2560, m_valid at last-accept+33.
REQ-035 Bench SHALL cover: 256 samples all s_dir=3, s_mag=255, ACC_W=16 -> m_peak=65280; with ACC_W=12 -> m_peak=4095 (saturated).
REQ-036 Bench SHALL cover: bins 5 and 20 each receive total 500, all others less -> m_bin=5 (tie to lowest index).
REQ-037 Bench SHALL cover: m_ready held low 10 cycles in OUT -> m_valid, m_bin, m_peak stable; s_ready=0 throughout.
REQ-038 Bench SHALL cover: after handshake, next window of 256 samples s_dir=31, s_mag=1 -> m_bin=31, m_peak=256.
- Proves CLEAR emptied all bins; s_ready low for exactly 32 cycles.
REQ-039 Bench SHALL cover: rst pulse after 100 samples -> m_valid stays 0.
- A fresh 256-sample window then gives a result with no contribution from the aborted samples.
